can_tx_scheduler: RTL
=====================

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of frame requesters (2..8).
REQ-002 SHALL have parameter MAX_RETRY, default 3, retransmissions allowed after a CAN error before failure.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, clk cycles allowed in WAIT before timeout failure.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester frame pending.
REQ-007 SHALL have port req_id  in  NUM_REQ*11  per-requester 11-bit CAN ID, requester i at bits [11i+10:11i].
REQ-008 SHALL have port req_dlc  in  NUM_REQ*4  per-requester data length code.
REQ-009 SHALL have port req_data  in  NUM_REQ*64  per-requester payload, byte 0 in bits [7:0] of each slice.
REQ-010 SHALL have port req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-011 SHALL have port can_tx_valid, can_tx_id[10:0], can_tx_dlc[3:0], can_tx_data[63:0]  out  frame to CAN controller.
REQ-012 SHALL have port can_tx_ready  in  1  controller accepts the frame when high with can_tx_valid.
REQ-013 SHALL have ports can_tx_done, can_tx_err  in  1 each  controller pulses: frame sent, or error/arbitration lost.
REQ-014 SHALL have ports done_valid, done_ok  out  1 each, and done_src  out  $clog2(NUM_REQ): completion report.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, SEND, WAIT and REPORT.
REQ-017 IDLE: when any req_valid bit is high, the block SHALL select the requester with the numerically lowest req_id, breaking ties by lowest index.
REQ-018 IDLE: on selection, the block SHALL latch the requester's id, dlc, data and index, pulse req_ready[sel] in the same cycle, clear the retry count and go to SEND.
REQ-019 The requester SHALL drop or replace its request after req_ready, and the latched frame SHALL be immune to later input changes.
REQ-020 SEND: can_tx_valid SHALL be high with the latched fields stable, holding until can_tx_ready is high, then go to WAIT and clear the timeout counter.
REQ-021 Handshake rule: can_tx_valid SHALL never drop before can_tx_ready, and the first cycle of can_tx_valid SHALL be the cycle after the IDLE accept.
REQ-022 WAIT: on can_tx_done the block SHALL go to REPORT with ok=1, and can_tx_done SHALL win if can_tx_done and can_tx_err are high together.
REQ-023 WAIT, on can_tx_err: if the retry count is below MAX_RETRY, the block SHALL increment it and return to SEND with the same frame; otherwise it SHALL go to REPORT with ok=0.
REQ-024 WAIT: the timeout counter SHALL increment each cycle, and on reaching TIMEOUT_CYC-1 with no done/err the block SHALL go to REPORT with ok=0 (no retry).
REQ-025 REPORT: done_valid SHALL pulse for exactly one cycle with done_src equal to the latched index and done_ok equal to the result, then the block SHALL go to IDLE.
REQ-026 The block SHALL arbitrate anew only in IDLE, so a new lower-ID request never pre-empts a frame in flight.
REQ-027 can_tx_done and can_tx_err SHALL be ignored in IDLE, SEND and REPORT.
REQ-028 req_ready SHALL be all zeros except during the single IDLE accept cycle.
REQ-029 The retry counter width SHALL hold MAX_RETRY without wrap, and the timeout counter width SHALL be $clog2(TIMEOUT_CYC).
REQ-030 Back-to-back operation: the earliest next accept SHALL be the cycle after REPORT, giving a minimum of 4 cycles from accept to accept with zero-latency ready/done.

Reset
REQ-031 On rst_n low, the block SHALL go immediately to IDLE without waiting for clk.
REQ-032 On rst_n low, all outputs (req_ready, can_tx_valid, can_tx_id/dlc/data, done_valid, done_ok, done_src, busy) SHALL go to 0.
REQ-033 On rst_n low, the retry and timeout counters SHALL clear.
REQ-034 Reset mid-operation SHALL abandon the in-flight frame with no done_valid report.
REQ-035 The first accept SHALL be possible in the first clk edge after rst_n deasserts.

Verification
REQ-036 Single request: req_valid=0001, id=0x123, dlc=8, data=0x0807060504030201, ready tied high, done 3 cycles later -> req_ready=0001 one cycle, frame on can_tx_*, done_valid with src=0, ok=1.
REQ-037 Arbitration: requesters 0..3 valid with ids 0x400,0x0A0,0x0A0,0x7FF -> order of service is 1,2,0,3.
REQ-038 Retry: can_tx_err pulsed 3 times then can_tx_done -> 4 can_tx_valid handshakes, done_ok=1; with 4 errors -> 4 handshakes, done_ok=0.
REQ-039 Backpressure/timeout: can_tx_ready low 20 cycles -> valid and fields stable for all 20; TIMEOUT_CYC=16 with no done/err -> done_ok=0 exactly 16 cycles after the handshake, then REPORT.
REQ-040 Simultaneous/reset: done and err in the same cycle -> done_ok=1, no retry; rst_n low during WAIT -> all outputs 0 at once, no done_valid, and next request accepted normally.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: lowest-ID arbitration across requesters, single frame in flight,
// retry on controller error, WAIT timeout, and a one-cycle completion report.
module can_tx_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*11-1:0]      req_id,
  input  logic [NUM_REQ*4-1:0]       req_dlc,
  input  logic [NUM_REQ*64-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       can_tx_valid,
  output logic [10:0]                can_tx_id,
  output logic [3:0]                 can_tx_dlc,
  output logic [63:0]                can_tx_data,
  input  logic                       can_tx_ready,
  input  logic                       can_tx_done,
  input  logic                       can_tx_err,
  output logic                       done_valid,
  output logic                       done_ok,
  output logic [$clog2(NUM_REQ)-1:0] done_src,
  output logic                       busy
);

  localparam int unsigned SrcW   = $clog2(NUM_REQ);
  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned TmoW   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StReport} state_e;

  state_e            state_q, state_d;
  logic [10:0]       id_q, id_d;
  logic [3:0]        dlc_q, dlc_d;
  logic [63:0]       data_q, data_d;
  logic [SrcW-1:0]   src_q, src_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              ok_q, ok_d;

  logic              found;
  logic [SrcW-1:0]   sel_idx;
  logic [10:0]       sel_id;
  logic [3:0]        sel_dlc;
  logic [63:0]       sel_data;

  // Strict less-than keeps the lowest index on equal IDs.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    sel_id   = '0;
    sel_dlc  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (!found || (req_id[11*i +: 11] < sel_id))) begin
        found    = 1'b1;
        sel_idx  = SrcW'(i);
        sel_id   = req_id[11*i +: 11];
        sel_dlc  = req_dlc[4*i +: 4];
        sel_data = req_data[64*i +: 64];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    dlc_d     = dlc_q;
    data_d    = data_q;
    src_d     = src_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    ok_d      = ok_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so the accept pulse is also forced low while reset is held.
        if (found && rst_n) begin
          req_ready[sel_idx] = 1'b1;
          id_d    = sel_id;
          dlc_d   = sel_dlc;
          data_d  = sel_data;
          src_d   = sel_idx;
          retry_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (can_tx_ready) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (can_tx_done) begin
          ok_d    = 1'b1;
          state_d = StReport;
        end else if (can_tx_err) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StSend;
          end else begin
            ok_d    = 1'b0;
            state_d = StReport;
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          ok_d    = 1'b0;
          state_d = StReport;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= '0;
      dlc_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      dlc_q   <= dlc_d;
      data_q  <= data_d;
      src_q   <= src_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      ok_q    <= ok_d;
    end
  end

  assign can_tx_valid = (state_q == StSend);
  assign can_tx_id    = id_q;
  assign can_tx_dlc   = dlc_q;
  assign can_tx_data  = data_q;
  assign done_valid   = (state_q == StReport);
  assign done_ok      = ok_q;
  assign done_src     = src_q;
  assign busy         = (state_q != StIdle);

endmodule
